// File: rtl/ascon_pack.sv
// Shared ASCON types and linear-layer rotation constants.
// Row i of type_state is state[i]; rotations are right rotations.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    // Rotation pairs per row: (19,28) (61,39) (1,6) (10,17) (7,41).
    localparam logic [4:0][5:0] ROT_A = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
    localparam logic [4:0][5:0] ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

    function automatic logic [63:0] ror64(
        input logic [63:0] x,
        input logic [5:0]  n
    );
        logic [6:0] m;
        m = 7'd64 - {1'b0, n};
        return (x >> n) | (x << m);
    endfunction

endpackage

// File: rtl/couche_diffusion_inv_pkg.sv
// Local types for the iterative inverse diffusion layer.
// Optional self-check is enabled with DIFF_INV_SELFCHECK_EN.
package couche_diffusion_inv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam int CNT_W = 6;

endpackage

// File: rtl/couche_diffusion.sv
// Combinational ASCON linear diffusion layer (one forward pass).
// Each row: x ^ (x >>> a) ^ (x >>> b).
module couche_diffusion
    import ascon_pack::*;
(
    input  type_state diff_i,
    output type_state diff_o
);

    for (genvar i = 0; i < 5; i++) begin : g_row
        assign diff_o[i] = diff_i[i]
                         ^ ror64(diff_i[i], ROT_A[i])
                         ^ ror64(diff_i[i], ROT_B[i]);
    end

endmodule

// File: rtl/couche_diffusion_inv.sv
// Inverse diffusion by NB_ITER repeated forward passes (order 64).
// Define DIFF_INV_SELFCHECK_EN to add err_o and a saved input copy.
module couche_diffusion_inv
    import ascon_pack::*;
    import couche_diffusion_inv_pkg::*;
#(
    parameter int NB_ITER = 63
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  type_state diff_i,
    output type_state diff_o,
`ifdef DIFF_INV_SELFCHECK_EN
    output logic      err_o,
`endif
    output logic      busy_o,
    output logic      done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB_ITER - 1);

    fsm_state_t       state_q;
    fsm_state_t       state_d;
    type_state        state_reg;
    type_state        pass_out;
    logic [CNT_W-1:0] cnt_q;
    logic             load;
    logic             step;
    logic             last;

    assign last   = (cnt_q == LAST);
    assign diff_o = state_reg;

    // Shared by the RUN pass and, in DONE, the forward re-check.
    couche_diffusion u_diff (
        .diff_i (state_reg),
        .diff_o (pass_out)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start_i ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        case (state_q)
            IDLE: load = start_i;
            RUN: begin
                busy_o = 1'b1;
                step   = 1'b1;
            end
            DONE: begin
                done_o = 1'b1;
                load   = start_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg <= '0;
            cnt_q     <= '0;
        end else if (load) begin
            state_reg <= diff_i;
            cnt_q     <= '0;
        end else if (step) begin
            state_reg <= pass_out;
            cnt_q     <= cnt_q + 1'b1;
        end
    end

`ifdef DIFF_INV_SELFCHECK_EN
    type_state saved_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            saved_q <= '0;
        end else if (load) begin
            saved_q <= diff_i;
        end
    end

    assign err_o = done_o && (pass_out != saved_q);
`endif

endmodule

// File: doc/couche_diffusion_inv.md
COUCHE_DIFFUSION_INV -- requirements
Module: couche_diffusion_inv

Interface
REQ-001 SHALL have parameter NB_ITER, default 63, number of forward-diffusion passes applied; 63 gives the exact inverse because the ASCON linear layer has order 64.
REQ-002 SHALL have port clock_i, input, 1, rising-edge clock.
REQ-003 SHALL have port reset_i, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port start_i, input, 1, one-cycle request to load diff_i and start inversion.
REQ-005 SHALL have port diff_i, input, type_state (5 x 64), state to un-diffuse.
REQ-006 SHALL have port diff_o, output, type_state, result register.
REQ-007 SHALL have port busy_o, output, 1, high while iterating.
REQ-008 SHALL have port done_o, output, 1, one-cycle pulse when diff_o is valid.

Function
REQ-009 SHALL use the FSM states IDLE, RUN and DONE.
REQ-010 SHALL, in IDLE or DONE with start_i=1, load diff_i into the state register, clear the 6-bit iteration counter and go to RUN.
REQ-011 SHALL, in RUN, replace each row per clock edge with x ^ (x>>>a) ^ (x>>>b), using right rotations (a,b) of (19,28), (61,39), (1,6), (10,17) and (7,41) for rows 0-4, and increment the counter.
REQ-012 SHALL go from RUN to DONE on the edge that applies pass NB_ITER, with the counter at NB_ITER-1.
REQ-013 SHALL give latency as: done_o=1 in the cycle after the NB_ITER-th edge following the start-sampling edge, i.e. 63 cycles for the default.
REQ-014 SHALL hold done_o for exactly one cycle, then return DONE to IDLE unless start_i=1.
REQ-015 SHALL hold diff_o stable from done_o until the next accepted start.
REQ-016 SHALL show the running state on diff_o during RUN, and downstream logic SHALL NOT use it then.
REQ-017 SHALL ignore start_i during RUN: no reload and no counter disturbance.
REQ-018 SHALL accept start_i coincident with done_o (back-to-back operation) and load the new diff_i on that edge.
REQ-019 SHALL, for NB_ITER=1, produce the forward diffusion; NB_ITER=0 is illegal.

Reset
REQ-020 SHALL, on a reset_i=1 edge, go to IDLE, clear diff_o to all-zero, clear the counter to 0, and set busy_o=0 and done_o=0.
REQ-021 SHALL treat reset during RUN as an abort: no done_o pulse, and the result is discarded.
REQ-022 SHALL give reset priority over start_i on the same edge.

Configuration
REQ-023 SHALL use the macro DIFF_INV_SELFCHECK_EN.
REQ-024 SHALL, when DIFF_INV_SELFCHECK_EN is defined, add output err_o (1 bit) and a saved copy of diff_i; in DONE, err_o SHALL be 1 if the forward diffusion of diff_o differs from the saved copy, valid together with done_o and reset to 0.
REQ-025 SHALL, when DIFF_INV_SELFCHECK_EN is undefined, omit err_o and the saved copy, with all other behaviour identical.

Structure
REQ-026 SHALL take type_state and the ten rotation constants from ascon_pack, with no local copies.
REQ-027 SHALL instantiate the existing combinational couche_diffusion as its single sub-module for the per-cycle pass and for the self-check, with no duplicated rotation logic.
REQ-028 SHALL implement the FSM, counter and state register in this module.

Verification
REQ-029 SHALL pass reset: assert reset_i for 2 cycles -> diff_o=0, busy_o=0, done_o=0, FSM in IDLE.
REQ-030 SHALL pass round trip: diff_i = {78e2cc41faabaa1a, bc7a2e775aababf7, 4b81c0cbbdb5fc1a, b22e133e424f0250, 044d33702433805d}, pulse start_i -> done_o exactly 63 cycles later; feeding diff_o through couche_diffusion returns the original 5 words; err_o=0 when enabled.
REQ-031 SHALL pass the zero/identity check: all-zero diff_i -> all-zero diff_o; NB_ITER=64 build -> diff_o equals diff_i.
REQ-032 SHALL pass start during RUN: second start_i at cycle 20 with different data -> first result unchanged and done_o still at cycle 63.
REQ-033 SHALL pass back-to-back: start_i high with done_o -> second done_o 63 cycles later with a correct second result.
REQ-034 SHALL pass mid-run reset: reset_i at cycle 30 -> no done_o, diff_o=0, and a subsequent start completes normally.
